// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: M-extension op encodings, sequencer states and
// the iteration-step mode used by the multiply/divide unit.
package riscv_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } muldiv_state_e;

  typedef enum logic {
    STEP_MUL,
    STEP_DIV
  } step_mode_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply on {product_hi, multiplier},
// subtract-restore-shift for divide on {remainder, dividend/quotient}.
module muldiv_step
  import riscv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   operand,
  input  step_mode_e     mode,
  output logic [2*W-1:0] acc_next
);

  logic [W:0] sum;
  logic [W:0] rem_sh;
  logic [W:0] diff;

  assign sum    = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : '0);
  assign rem_sh = {acc[2*W-1:W], acc[W-1]};
  assign diff   = rem_sh - {1'b0, operand};

  // NOTE: acc_next gets a default first so no path through this block infers a latch.
  always_comb begin
    acc_next = acc;
    case (mode)
      STEP_MUL: acc_next = {sum, acc[W-1:1]};
      STEP_DIV: begin
        // diff[W] set means the trial subtraction went negative: restore.
        if (!diff[W]) acc_next = {diff[W-1:0], acc[W-2:0], 1'b1};
        else          acc_next = {rem_sh[W-1:0], acc[W-2:0], 1'b0};
      end
      default: acc_next = acc;
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit for the execute stage; stalls the
// pipeline while it steps through DATA_WIDTH iterations on operand magnitudes.
module muldiv_sequencer
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  flush,
  output logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int               W        = DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W);
  localparam logic [W-1:0]     MIN_INT  = {1'b1, {(W-1){1'b0}}};

  muldiv_state_e    state_q, state_d;
  muldiv_op_e       op_in, op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2*W-1:0]   acc_q, acc_next;
  logic [W-1:0]     opnd_q;
  logic             neg_q;

  logic             a_neg, b_neg, neg_in, div_zero, overflow, special;
  logic [W-1:0]     a_mag, b_mag, special_res;
  step_mode_e       mode;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     quot_fix, rem_fix, final_res;

  // Operand decode happens on the raw inputs so IDLE can latch magnitudes directly.
  assign op_in    = muldiv_op_e'(Funct3);
  assign a_neg    = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && SrcA[W-1];
  assign b_neg    = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && SrcB[W-1];
  assign a_mag    = a_neg ? -SrcA : SrcA;
  assign b_mag    = b_neg ? -SrcB : SrcB;
  assign neg_in   = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
  assign div_zero = Funct3[2] && (SrcB == '0);
  assign overflow = (op_in inside {OP_DIV, OP_REM}) && (SrcA == MIN_INT) && (SrcB == '1);
  assign special  = div_zero || overflow;
  // Funct3[1] separates remainder ops from quotient ops within the divide group.
  assign special_res = div_zero ? (Funct3[1] ? SrcA : '1)
                                : (Funct3[1] ? '0   : MIN_INT);

  assign mode = (op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) ? STEP_DIV : STEP_MUL;

  muldiv_step #(.W(W)) u_step (
    .acc      (acc_q),
    .operand  (opnd_q),
    .mode     (mode),
    .acc_next (acc_next)
  );

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quot_fix = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem_fix  = neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_comb begin
    final_res = rem_fix;
    case (op_q)
      OP_MUL:                        final_res = prod_fix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:               final_res = quot_fix;
      default:                       final_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: if (start && !flush) begin
        stall   = 1'b1;
        state_d = special ? DONE : CALC;
      end
      CALC: begin
        stall = 1'b1;
        if (flush)                  state_d = IDLE;
        else if (cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE) && !flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      Result  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start && !flush) begin
          op_q  <= op_in;
          cnt_q <= '0;
          if (special) begin
            Result <= special_res;
          end else begin
            acc_q  <= {{W{1'b0}}, a_mag};
            opnd_q <= b_mag;
            neg_q  <= neg_in;
          end
        end
        CALC: if (!flush) begin
          if (cnt_q == LAST_CNT) begin
            Result <= final_res;
          end else begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, flush;
  logic [2:0]   Funct3;
  logic [W-1:0] SrcA, SrcB;
  logic         stall, busy, done;
  logic [W-1:0] Result;

  always #5 clk = ~clk;

  muldiv_sequencer #(.DATA_WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .Funct3 (Funct3),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .Result (Result)
  );

  typedef struct {
    string        name;
    logic [W-1:0] res;
    int           lat;
    int           issue_cyc;
  } exp_t;

  typedef struct {
    logic [2:0]   f3;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    int           lat;
    string        name;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  int   stall_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 with Result %h, expected no pending op", Result);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, " result"}, Result, mon_e.res);
        check({mon_e.name, " latency"}, cyc - mon_e.issue_cyc, mon_e.lat);
        check({mon_e.name, " stall_cycles"}, stall_run, mon_e.lat);
        check({mon_e.name, " stall_at_done"}, {31'b0, stall}, 0);
      end
    end
    stall_run = (stall === 1'b1) ? stall_run + 1 : 0;
  end

  task automatic issue(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input int lat, input string name,
                       input bit push, input bit hold);
    @(negedge clk);
    #1;
    start  = 1'b1;
    Funct3 = f3;
    SrcA   = a;
    SrcB   = b;
    #1;
    check({name, " stall_on_issue"}, {31'b0, stall}, 1);
    check({name, " idle_on_issue"}, {31'b0, busy}, 0);
    @(posedge clk);
    if (push) exp_q.push_back('{name, res, lat, cyc + 1});
    if (!hold) begin
      @(negedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0) break;
    end
    start = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL timeout: got %0d pending ops, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    reset  = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    Funct3 = 3'b000;
    SrcA   = '0;
    SrcB   = '0;
    #1;
    check("reset Result", Result, 0);
    check("reset flags", {29'b0, stall, busy, done}, 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;

    vecs.push_back('{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul_7_m3"});
    vecs.push_back('{3'b001, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 33, "mulh_7_m3"});
    vecs.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh_min"});
    vecs.push_back('{3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulhu_min"});
    vecs.push_back('{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu_m1"});
    vecs.push_back('{3'b101, 32'd100,      32'd7,        32'd14,       33, "divu_100_7"});
    vecs.push_back('{3'b111, 32'd100,      32'd7,        32'd2,        33, "remu_100_7"});
    vecs.push_back('{3'b100, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 33, "div_m100_7"});
    vecs.push_back('{3'b110, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 33, "rem_m100_7"});
    vecs.push_back('{3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33, "div_100_m7"});
    vecs.push_back('{3'b110, 32'd100,      32'hFFFFFFF9, 32'd2,        33, "rem_100_m7"});
    vecs.push_back('{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 0,  "div_by_zero"});
    vecs.push_back('{3'b110, 32'd5,        32'd0,        32'd5,        0,  "rem_by_zero"});
    vecs.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0,  "div_overflow"});
    vecs.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0,  "rem_overflow"});
    vecs.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu_max"});

    foreach (vecs[i]) begin
      issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, vecs[i].name, 1'b1, 1'b0);
      wait_drain(60);
    end

    // Flush ten cycles into CALC: no done, Result keeps the previous value.
    issue(3'b000, 32'd123, 32'd456, '0, 0, "mul_flushed", 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    #1;
    flush = 1'b0;
    check("flush busy", {31'b0, busy}, 0);
    check("flush stall", {31'b0, stall}, 0);
    check("flush Result", Result, 32'hFFFFFFFE);
    issue(3'b101, 32'd9, 32'd3, 32'd3, 33, "divu_after_flush", 1'b1, 1'b0);
    wait_drain(60);

    // start held high through a whole op: exactly one done pulse.
    d0 = done_cnt;
    issue(3'b101, 32'd100, 32'd7, 32'd14, 33, "divu_held_start", 1'b1, 1'b1);
    wait_drain(60);
    repeat (3) @(negedge clk);
    check("held_start done_count", done_cnt - d0, 1);
    check("held_start idle", {31'b0, busy}, 0);

    // Asynchronous reset mid-CALC discards the op.
    issue(3'b000, 32'd77, 32'd11, '0, 0, "mul_reset", 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("midop_reset Result", Result, 0);
    check("midop_reset flags", {29'b0, stall, busy, done}, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    repeat (40) @(negedge clk);
    check("post_reset busy", {31'b0, busy}, 0);
    check("post_reset Result", Result, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
